// File: rtl/load_store_unit_if.sv
// Bus bundle between the pipeline/memory environment and load_store_unit.
// The master modport is the environment side; slave is the LSU side.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  iReqValid;
  logic                  oReqReady;
  logic                  iWrite;
  logic [2:0]            iFunct3;
  logic [ADDR_WIDTH-1:0] iAddr;
  logic [DATA_WIDTH-1:0] iWrData;
  logic                  oRespValid;
  logic                  iRespReady;
  logic [DATA_WIDTH-1:0] oRdData;
  logic                  oErr;
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic                  oMemWriteEn;
  logic [DATA_WIDTH-1:0] oMemWrData;
  logic [DATA_WIDTH-1:0] iMemRdData;

  modport master (
    output iReqValid, iWrite, iFunct3, iAddr, iWrData, iRespReady, iMemRdData,
    input  oReqReady, oRespValid, oRdData, oErr, oMemAddr, oMemWriteEn, oMemWrData
  );

  modport slave (
    input  iReqValid, iWrite, iFunct3, iAddr, iWrData, iRespReady, iMemRdData,
    output oReqReady, oRespValid, oRdData, oErr, oMemAddr, oMemWriteEn, oMemWrData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word accesses over a word-wide memory using read-modify-write.
// Define MISALIGNED_EN to split word-crossing accesses into two memory words.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              iClk,
  input logic              iRstN,
  load_store_unit_if.slave bus
);

`ifdef MISALIGNED_EN
  localparam int unsigned WinW = 2 * DATA_WIDTH;
  typedef enum logic [2:0] {
    StIdle, StRdA, StCapA, StRdB, StCapB, StWrA, StWrB, StResp
  } state_e;
`else
  localparam int unsigned WinW = DATA_WIDTH;
  typedef enum logic [2:0] {StIdle, StRdA, StCapA, StWrA, StResp} state_e;
`endif
  localparam int unsigned Lanes = WinW / 8;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [1:0]            r_offset;
  logic [2:0]            r_funct3;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_word_a;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;
`ifdef MISALIGNED_EN
  logic                  r_split;
  logic [DATA_WIDTH-1:0] r_word_b;
`endif

  logic [2:0] w_req_size;
  logic       w_req_split;
  logic       w_req_illegal;
  logic       w_req_err;
  logic       w_req_fast_sw;

  always_comb begin
    case (bus.iFunct3[1:0])
      2'd0:    w_req_size = 3'd1;
      2'd1:    w_req_size = 3'd2;
      default: w_req_size = 3'd4;
    endcase
    w_req_split = ({1'b0, bus.iAddr[1:0]} + w_req_size) > 3'd4;
    if (bus.iWrite) begin
      w_req_illegal = bus.iFunct3 > 3'd2;
    end else begin
      w_req_illegal = bus.iFunct3 inside {3'd3, 3'd6, 3'd7};
    end
`ifdef MISALIGNED_EN
    w_req_err = w_req_illegal;
`else
    w_req_err = w_req_illegal | w_req_split;
`endif
    // A full aligned word overwrites every lane, so there is nothing to read back.
    w_req_fast_sw = bus.iWrite && (bus.iFunct3 == 3'd2) && (bus.iAddr[1:0] == 2'b00);
  end

  logic [4:0]            w_shamt;
  logic [3:0]            w_size_lanes;
  logic [Lanes-1:0]      w_lane_mask;
  logic [WinW-1:0]       w_bit_mask;
  logic [WinW-1:0]       w_wr_shifted;
  logic [WinW-1:0]       w_rd_back;
  logic [WinW-1:0]       w_rd_window;
  logic [WinW-1:0]       w_merged;
  logic [DATA_WIDTH-1:0] w_rd_aligned;
  logic [DATA_WIDTH-1:0] w_load_result;

  always_comb begin
    w_shamt = {r_offset, 3'b000};
    case (r_funct3[1:0])
      2'd0:    w_size_lanes = 4'b0001;
      2'd1:    w_size_lanes = 4'b0011;
      default: w_size_lanes = 4'b1111;
    endcase
    w_lane_mask = Lanes'(w_size_lanes) << r_offset;
    w_bit_mask  = '0;
    for (int i = 0; i < Lanes; i++) begin
      w_bit_mask[8*i +: 8] = {8{w_lane_mask[i]}};
    end
    w_wr_shifted = WinW'(r_wdata) << w_shamt;
`ifdef MISALIGNED_EN
    w_rd_back   = {r_word_b, r_word_a};
    // In the capture states the freshly returned word is not yet registered.
    w_rd_window = {(r_state == StCapB) ? bus.iMemRdData : r_word_b,
                   (r_state == StCapA) ? bus.iMemRdData : r_word_a};
`else
    w_rd_back   = r_word_a;
    w_rd_window = (r_state == StCapA) ? bus.iMemRdData : r_word_a;
`endif
    w_merged     = (w_rd_back & ~w_bit_mask) | (w_wr_shifted & w_bit_mask);
    w_rd_aligned = DATA_WIDTH'(w_rd_window >> w_shamt);
    case (r_funct3)
      3'd0:    w_load_result = {{(DATA_WIDTH-8){w_rd_aligned[7]}}, w_rd_aligned[7:0]};
      3'd4:    w_load_result = {{(DATA_WIDTH-8){1'b0}}, w_rd_aligned[7:0]};
      3'd1:    w_load_result = {{(DATA_WIDTH-16){w_rd_aligned[15]}}, w_rd_aligned[15:0]};
      3'd5:    w_load_result = {{(DATA_WIDTH-16){1'b0}}, w_rd_aligned[15:0]};
      default: w_load_result = w_rd_aligned;
    endcase
  end

  // Memory-side outputs decode straight from state so a reset kills them at once.
  always_comb begin
    bus.oReqReady   = (r_state == StIdle);
    bus.oRespValid  = (r_state == StResp);
    bus.oErr        = r_err;
    bus.oRdData     = r_rd_data;
    bus.oMemAddr    = '0;
    bus.oMemWriteEn = 1'b0;
    bus.oMemWrData  = '0;
    case (r_state)
      StRdA: bus.oMemAddr = r_addr_a;
      StWrA: begin
        bus.oMemAddr    = r_addr_a;
        bus.oMemWriteEn = 1'b1;
        bus.oMemWrData  = w_merged[DATA_WIDTH-1:0];
      end
`ifdef MISALIGNED_EN
      StRdB: bus.oMemAddr = r_addr_a + ADDR_WIDTH'(4);
      StWrB: begin
        bus.oMemAddr    = r_addr_a + ADDR_WIDTH'(4);
        bus.oMemWriteEn = 1'b1;
        bus.oMemWrData  = w_merged[WinW-1:DATA_WIDTH];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= StIdle;
      r_addr_a  <= '0;
      r_offset  <= '0;
      r_funct3  <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_word_a  <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
`ifdef MISALIGNED_EN
      r_split   <= 1'b0;
      r_word_b  <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.iReqValid) begin
            r_addr_a <= {bus.iAddr[ADDR_WIDTH-1:2], 2'b00};
            r_offset <= bus.iAddr[1:0];
            r_funct3 <= bus.iFunct3;
            r_write  <= bus.iWrite;
            r_wdata  <= bus.iWrData;
`ifdef MISALIGNED_EN
            r_split  <= w_req_split;
`endif
            if (w_req_err) begin
              r_err   <= 1'b1;
              r_state <= StResp;
            end else if (w_req_fast_sw) begin
              r_state <= StWrA;
            end else begin
              r_state <= StRdA;
            end
          end
        end
        StRdA: r_state <= StCapA;
        StCapA: begin
          r_word_a <= bus.iMemRdData;
`ifdef MISALIGNED_EN
          if (r_split) begin
            r_state <= StRdB;
          end else
`endif
          if (r_write) begin
            r_state <= StWrA;
          end else begin
            r_rd_data <= w_load_result;
            r_state   <= StResp;
          end
        end
`ifdef MISALIGNED_EN
        StRdB: r_state <= StCapB;
        StCapB: begin
          r_word_b <= bus.iMemRdData;
          if (r_write) begin
            r_state <= StWrA;
          end else begin
            r_rd_data <= w_load_result;
            r_state   <= StResp;
          end
        end
        StWrB: r_state <= StResp;
`endif
        StWrA: begin
          r_state <= StResp;
`ifdef MISALIGNED_EN
          if (r_split) r_state <= StWrB;
`endif
        end
        StResp: begin
          if (bus.iRespReady) begin
            r_state   <= StIdle;
            r_err     <= 1'b0;
            r_rd_data <= '0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written corner
// sequences, then random traffic checked against a byte-level reference model.
module tb_load_store_unit;

`ifdef MISALIGNED_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  // Word memory with one-cycle read latency; index is address bits [9:2].
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] mem_rd_q;
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (bus.oMemWriteEn) begin
      mem[bus.oMemAddr[9:2]] <= bus.oMemWrData;
      wr_log.push_back(bus.oMemAddr);
    end else if (bus.oMemAddr != 32'h0) begin
      rd_log.push_back(bus.oMemAddr);
    end
    mem_rd_q <= mem[bus.oMemAddr[9:2]];
  end
  assign bus.iMemRdData = mem_rd_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    bd_idx = idx;
    bd_data = data;
    bd_we = 1'b1;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem[a[9:2]][8*a[1:0] +: 8];
  endfunction

  // Reference: outcome of one request computed from access rules, bytes at a time.
  task automatic ref_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic e, output logic [31:0] d,
                         output int lat, output int nrd, output int nwr);
    int size;
    bit illegal, split;
    logic [31:0] ba;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    split = (int'(a[1:0]) + size) > 4;
    e = illegal || (split && !MIS);
    d = '0;
    nrd = 0;
    nwr = 0;
    lat = 1;
    if (!e && w) begin
      for (int i = 0; i < size; i++) begin
        ba = a + 32'(i);
        ref_mem[ba[9:2]][8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
      nwr = split ? 2 : 1;
      nrd = (size == 4 && a[1:0] == 2'b00) ? 0 : (split ? 2 : 1);
      lat = (nrd == 0) ? 2 : (split ? 7 : 4);
    end else if (!e) begin
      for (int i = 0; i < size; i++) d[8*i +: 8] = ref_byte(a + 32'(i));
      if (!f3[2] && size < 4 && d[8*size-1]) d = d | (32'hFFFF_FFFF << (8*size));
      nrd = split ? 2 : 1;
      lat = split ? 5 : 3;
    end
  endtask

  // Issues one request starting #1 after a posedge; returns #1 after a posedge.
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold,
                         output logic e, output logic [31:0] d, output int lat,
                         output int nrd, output int nwr,
                         output logic [31:0] rd0, output logic [31:0] rd1);
    int rs, ws, t;
    rs = rd_log.size();
    ws = wr_log.size();
    bus.iWrite = w;
    bus.iFunct3 = f3;
    bus.iAddr = a;
    bus.iWrData = wd;
    bus.iReqValid = 1'b1;
    t = 0;
    while (!bus.oReqReady && t < 10) begin
      @(posedge clk);
      #1 t++;
    end
    chk("req_ready_before_accept", 32'(bus.oReqReady), 32'd1);
    @(posedge clk);
    #1 bus.iReqValid = 1'b0;
    lat = 1;
    while (!bus.oRespValid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    e = bus.oErr;
    d = bus.oRdData;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_resp_valid", 32'(bus.oRespValid), 32'd1);
      chk("hold_rd_data", bus.oRdData, d);
      chk("hold_err", 32'(bus.oErr), 32'(e));
      chk("hold_req_ready", 32'(bus.oReqReady), 32'd0);
    end
    bus.iRespReady = 1'b1;
    @(posedge clk);
    #1 bus.iRespReady = 1'b0;
    chk("resp_released", 32'(bus.oRespValid), 32'd0);
    nrd = rd_log.size() - rs;
    nwr = wr_log.size() - ws;
    rd0 = (nrd > 0) ? rd_log[rs] : 32'h0;
    rd1 = (nrd > 1) ? rd_log[rs+1] : 32'h0;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre_a;
    logic [31:0] pre_b;
    logic        err;
    logic [31:0] data;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] post_a;
    logic [31:0] post_b;
  } vec_t;

  initial begin
    vec_t        vecs[14];
    logic        e, ee;
    logic [31:0] d, ed, r0, r1;
    int          lat, nrd, nwr, elat, enrd, enwr, mism;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a, wd;

    // Memory word 0 is 0x10000, word 1 is 0x10004.
    vecs[0]  = '{1'b0, 3'd2, 32'h10000, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'hDEADBEEF, 3, 1, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[1]  = '{1'b0, 3'd0, 32'h10003, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'hFFFFFFDE, 3, 1, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[2]  = '{1'b0, 3'd4, 32'h10003, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'h000000DE, 3, 1, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[3]  = '{1'b0, 3'd1, 32'h10002, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'hFFFFDEAD, 3, 1, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[4]  = '{1'b0, 3'd5, 32'h10000, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'h0000BEEF, 3, 1, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[5]  = '{1'b1, 3'd0, 32'h10001, 32'h5A, 32'h11223344, 32'h01234567,
                 1'b0, 32'h0, 4, 1, 1, 32'h11225A44, 32'h01234567};
    vecs[6]  = '{1'b1, 3'd2, 32'h10000, 32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'h0, 2, 0, 1, 32'hCAFEF00D, 32'h01234567};
    vecs[7]  = '{1'b1, 3'd1, 32'h10002, 32'h99991234, 32'hDEADBEEF, 32'h01234567,
                 1'b0, 32'h0, 4, 1, 1, 32'h1234BEEF, 32'h01234567};
    vecs[8]  = '{1'b0, 3'd3, 32'h10000, 32'h0, 32'hDEADBEEF, 32'h01234567,
                 1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
    vecs[9]  = '{1'b1, 3'd4, 32'h10000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h01234567,
                 1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
    if (MIS) begin
      vecs[10] = '{1'b0, 3'd2, 32'h10002, 32'h0, 32'hDEADBEEF, 32'h01234567,
                   1'b0, 32'h4567DEAD, 5, 2, 0, 32'hDEADBEEF, 32'h01234567};
      vecs[11] = '{1'b0, 3'd1, 32'h10003, 32'h0, 32'hDEADBEEF, 32'h01234567,
                   1'b0, 32'h000067DE, 5, 2, 0, 32'hDEADBEEF, 32'h01234567};
      vecs[12] = '{1'b1, 3'd1, 32'h10003, 32'h0000ABCD, 32'hDEADBEEF, 32'h01234567,
                   1'b0, 32'h0, 7, 2, 2, 32'hCDADBEEF, 32'h012345AB};
      vecs[13] = '{1'b1, 3'd2, 32'h10001, 32'h11223344, 32'hDEADBEEF, 32'h01234567,
                   1'b0, 32'h0, 7, 2, 2, 32'h223344EF, 32'h01234511};
    end else begin
      vecs[10] = '{1'b0, 3'd2, 32'h10002, 32'h0, 32'hDEADBEEF, 32'h01234567,
                   1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
      vecs[11] = '{1'b0, 3'd1, 32'h10003, 32'h0, 32'hDEADBEEF, 32'h01234567,
                   1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
      vecs[12] = '{1'b1, 3'd1, 32'h10003, 32'h0000ABCD, 32'hDEADBEEF, 32'h01234567,
                   1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
      vecs[13] = '{1'b1, 3'd2, 32'h10001, 32'h11223344, 32'hDEADBEEF, 32'h01234567,
                   1'b1, 32'h0, 1, 0, 0, 32'hDEADBEEF, 32'h01234567};
    end

    rst_n = 1'b0;
    bus.iReqValid = 1'b0;
    bus.iWrite = 1'b0;
    bus.iFunct3 = 3'd0;
    bus.iAddr = 32'h0;
    bus.iWrData = 32'h0;
    bus.iRespReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.oRespValid), 32'd0);
    chk("rst_err", 32'(bus.oErr), 32'd0);
    chk("rst_rd_data", bus.oRdData, 32'h0);
    chk("rst_mem_we", 32'(bus.oMemWriteEn), 32'd0);
    chk("rst_mem_addr", bus.oMemAddr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_req_ready", 32'(bus.oReqReady), 32'd1);

    foreach (vecs[i]) begin
      poke(8'd0, vecs[i].pre_a);
      poke(8'd1, vecs[i].pre_b);
      run_txn(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, (i == 8) ? 5 : 0,
              e, d, lat, nrd, nwr, r0, r1);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_data", i), d, vecs[i].data);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_reads", i), nrd, vecs[i].nrd);
      chk($sformatf("vec%0d_writes", i), nwr, vecs[i].nwr);
      chk($sformatf("vec%0d_word_a", i), mem[0], vecs[i].post_a);
      chk($sformatf("vec%0d_word_b", i), mem[1], vecs[i].post_b);
      if (nrd > 0) chk($sformatf("vec%0d_read0_addr", i), r0, 32'h10000);
      if (nrd > 1) chk($sformatf("vec%0d_read1_addr", i), r1, 32'h10004);
    end

    // Reset asserted while a byte store sits in its write state.
    poke(8'd0, 32'h11223344);
    bus.iWrite = 1'b1;
    bus.iFunct3 = 3'd0;
    bus.iAddr = 32'h10001;
    bus.iWrData = 32'h5A;
    bus.iReqValid = 1'b1;
    @(posedge clk);
    #1 bus.iReqValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("wra_write_strobe", 32'(bus.oMemWriteEn), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(bus.oMemWriteEn), 32'd0);
    chk("midrst_mem_addr", bus.oMemAddr, 32'h0);
    chk("midrst_mem_wdata", bus.oMemWrData, 32'h0);
    chk("midrst_resp_valid", 32'(bus.oRespValid), 32'd0);
    chk("midrst_err", 32'(bus.oErr), 32'd0);
    chk("midrst_rd_data", bus.oRdData, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_req_ready", 32'(bus.oReqReady), 32'd1);
    chk("postrst_resp_valid", 32'(bus.oRespValid), 32'd0);
    chk("postrst_word_kept", mem[0], 32'h11223344);

    // Random traffic against the reference model.
    for (int k = 0; k < 256; k++) poke(8'(k), $urandom);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (w && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a = 32'h10000 + 32'($urandom_range(0, 1023));
      wd = $urandom;
      ref_txn(w, f3, a, wd, ee, ed, elat, enrd, enwr);
      run_txn(w, f3, a, wd, $urandom_range(0, 2), e, d, lat, nrd, nwr, r0, r1);
      chk($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
      chk($sformatf("rnd%0d_data", n), d, ed);
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_reads", n), nrd, enrd);
      chk($sformatf("rnd%0d_writes", n), nwr, enwr);
      mism = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) mism++;
      chk($sformatf("rnd%0d_mem_words_differing", n), mism, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
